// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: fetch FSM states, PC step, instruction field positions
// and the sign-extension helper for the decoded word offset.
package cpu_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    ISSUE    = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction field positions (msb/lsb).
  localparam int unsigned OPCODE_MSB    = 31;
  localparam int unsigned OPCODE_LSB    = 24;
  localparam int unsigned OFFSET_MSB    = 23;
  localparam int unsigned OFFSET_LSB    = 16;
  localparam int unsigned WRITEREG_MSB  = 18;
  localparam int unsigned WRITEREG_LSB  = 16;
  localparam int unsigned READREG1_MSB  = 10;
  localparam int unsigned READREG1_LSB  = 8;
  localparam int unsigned READREG2_MSB  = 2;
  localparam int unsigned READREG2_LSB  = 0;
  localparam int unsigned IMMEDIATE_MSB = 7;
  localparam int unsigned IMMEDIATE_LSB = 0;

  // Word offset to 32-bit byte displacement.
  function automatic logic [31:0] offset_to_bytes(input logic [7:0] offset);
    logic [31:0] ext;
    ext = {{24{offset[7]}}, offset};
    return ext << 2;
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational next-PC arithmetic, reusable by the datapath.
//   pc_i        : current PC
//   offset_i    : signed 8-bit word offset
//   pc_plus4_o  : pc_i + 4
//   target_o    : pc_i + 4 + sext(offset_i) * 4 (mod 2^32)
module branch_target_adder
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [7:0]  offset_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o
);

  always_comb begin
    pc_plus4_o = pc_i + PC_STEP;
    target_o   = pc_plus4_o + offset_to_bytes(offset_i);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs the instruction-memory read handshake
// (with busywait), holds the fetched word for the decoder and counts retired instructions.
//   CLK, RESET                : clock, asynchronous active-high reset
//   IMEM_READ / IMEM_ADDRESS  : read request and word address (PC[ADDR_W+1:2])
//   IMEM_READDATA / _BUSYWAIT : returned word and memory-not-ready flag
//   STALL                     : hold the issued instruction
//   JUMP / BRANCH_TAKEN       : redirect to PC + 4 + OFFSET*4 on instruction completion
//   OFFSET                    : signed word offset from decode
//   PC / INSTRUCTION          : current instruction address and registered word
//   INSTR_VALID               : INSTRUCTION is valid for execution this cycle
//   RETIRED                   : completed-instruction count (mod 2^32)
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              IMEM_READ,
  output logic [ADDR_W-1:0] IMEM_ADDRESS,
  input  logic [31:0]       IMEM_READDATA,
  input  logic              IMEM_BUSYWAIT,
  input  logic              STALL,
  input  logic              JUMP,
  input  logic              BRANCH_TAKEN,
  input  logic [7:0]        OFFSET,
  output logic [31:0]       PC,
  output logic [31:0]       INSTRUCTION,
  output logic              INSTR_VALID,
  output logic [31:0]       RETIRED
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  pc_plus4, pc_target;

  branch_target_adder u_branch_target_adder (
    .pc_i       (pc_q),
    .offset_i   (OFFSET),
    .pc_plus4_o (pc_plus4),
    .target_o   (pc_target)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= RST_WAIT;
      pc_q      <= PC_RESET;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_READDATA;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Redirect inputs only matter on the completing edge.
        if (!STALL) begin
          pc_d      = (JUMP || BRANCH_TAKEN) ? pc_target : pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      default: state_d = RST_WAIT;
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    IMEM_READ    = (state_q == FETCH);
    INSTR_VALID  = (state_q == ISSUE);
    IMEM_ADDRESS = pc_q[ADDR_W+1:2];
    PC           = pc_q;
    INSTRUCTION  = instr_q;
    RETIRED      = retired_q;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer for the 8-bit single-cycle/multi-cycle CPU. Owns the program counter and drives the instruction-memory read handshake, including `BUSYWAIT` stalls. Presents each fetched 32-bit word to the instruction decoder with a one-cycle valid strobe. Applies the next-PC rule (sequential, jump, or taken branch using the decoded 8-bit word offset).

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width; memory address is `PC[ADDR_W+1:2]`.
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `CLK` input 1: single clock, rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `IMEM_READ` output 1: read request to instruction memory.
- `IMEM_ADDRESS` output ADDR_W: word address, always equal to `PC[ADDR_W+1:2]`.
- `IMEM_READDATA` input 32: instruction word from memory.
- `IMEM_BUSYWAIT` input 1: memory not ready; read data is valid only when `IMEM_READ=1` and `IMEM_BUSYWAIT=0`.
- `STALL` input 1: datapath/data-memory busy; holds the issued instruction.
- `JUMP` input 1: current instruction is an unconditional jump.
- `BRANCH_TAKEN` input 1: current instruction is a branch whose condition holds.
- `OFFSET` input 8: signed word offset from decode (`INSTRUCTION[23:16]`).
- `PC` output 32: address of the instruction currently fetched or issued.
- `INSTRUCTION` output 32: registered instruction word to the decoder.
- `INSTR_VALID` output 1: `INSTRUCTION` is valid for execution this cycle.
- `RETIRED` output 32: count of instructions completed (ISSUE exits).

## Operation
- States (`fetch_state_t`): RST_WAIT, FETCH, ISSUE.
- RST_WAIT
  - Entered asynchronously on `RESET`.
  - Outputs: `PC=PC_RESET`, `INSTRUCTION=0`, `INSTR_VALID=0`, `IMEM_READ=0`, `RETIRED=0`.
  - Moves to FETCH on the first clock edge after `RESET` deasserts.
- FETCH
  - `IMEM_READ=1`, `INSTR_VALID=0`.
  - While `IMEM_BUSYWAIT=1`: remain in FETCH; PC and `INSTRUCTION` held.
  - When `IMEM_BUSYWAIT=0`: capture `IMEM_READDATA` into `INSTRUCTION` at the edge, then go to ISSUE.
- ISSUE
  - `IMEM_READ=0`, `INSTR_VALID=1`.
  - If `STALL=1`: remain in ISSUE; `INSTRUCTION`, `PC` and `INSTR_VALID` held; `JUMP`, `BRANCH_TAKEN` and `OFFSET` ignored.
  - If `STALL=0`: at the edge, update PC, increment `RETIRED` (mod 2^32) and go to FETCH.
    - If `JUMP` or `BRANCH_TAKEN`: `PC <= PC + 4 + (sext32(OFFSET) << 2)`.
    - Otherwise: `PC <= PC + 4`.
- Arithmetic
  - All PC arithmetic is 32-bit, modulo 2^32. Wrap past 32'hFFFF_FFFC to 0 is legal and silent.
  - `OFFSET` is two's complement, range −128..+127 words.
- `JUMP` and `BRANCH_TAKEN` both high: same target as either alone.
- `IMEM_BUSYWAIT` outside FETCH is ignored.
- Reset mid-FETCH (memory busy) or mid-ISSUE (stalled): outputs go to reset values immediately (asynchronous). No partial PC update; the count is not incremented.

## Timing
- Zero-wait memory: 2 cycles per instruction (FETCH 1, ISSUE 1).
- Each memory busy cycle adds 1 cycle; each `STALL` cycle adds 1 cycle.
- `IMEM_READ` and `INSTR_VALID` are registered-state decodes (Moore) and are never high in the same cycle.
- `INSTRUCTION` changes only on the FETCH→ISSUE edge. It is stable throughout ISSUE.
- `IMEM_ADDRESS` is stable for the whole FETCH interval, including busy cycles.
- First `IMEM_READ=1` occurs in the first cycle after the post-reset edge.
- PC update is visible on the first FETCH cycle of the next instruction.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum.
  - `PC_STEP = 4`.
  - Instruction field position constants (OPCODE [31:24], OFFSET [23:16], WRITEREG [18:16], READREG1 [10:8], READREG2 [2:0], IMMEDIATE [7:0]).
- One sub-module, `branch_target_adder`:
  - Combinational.
  - Inputs: PC, OFFSET. Output: `PC+4` and branch target.
  - Reusable by the datapath.
- Sequencer top holds the FSM, PC register, instruction register and retired counter.

## Test plan
- Reset then zero-wait memory returning 32'h0102_0304:
  - `IMEM_READ` high in cycle 1 with address 0.
  - `INSTR_VALID` high in cycle 2 with `INSTRUCTION=32'h0102_0304`.
  - Next fetch at address 1 (PC=4); `RETIRED=1`.
- `IMEM_BUSYWAIT` high for 3 cycles in FETCH:
  - `IMEM_ADDRESS` constant and `INSTR_VALID=0` for 4 cycles.
  - Data is captured only on the non-busy edge.
- PC=8, `JUMP=1`, `OFFSET=8'hFE`: next PC = 8+4−8 = 4. With `OFFSET=8'h03`, `BRANCH_TAKEN=1`: next PC = 24.
- `STALL` high for 2 cycles in ISSUE:
  - `INSTR_VALID` high for 3 cycles with `INSTRUCTION` unchanged.
  - PC advances by 4 only once; `RETIRED` increments once.
- PC=32'hFFFF_FFFC, no branch: next PC = 0, address 0.
- `RESET` pulsed mid-busy-FETCH at PC=12:
  - `IMEM_READ` drops in the same cycle (asynchronous).
  - PC=0 and `RETIRED=0`; fetch restarts at address 0.
